// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-bit count and codeword position/index mapping.
// Used by both encoder and decoder so the bit layout is defined in one place.
package hamming_pkg;

  typedef enum logic [1:0] {HD_OK, HD_CORR, HD_UNC} hd_status_e;

  function automatic int calc_m(input int k);
    if (k <= 1)         return 2;
    else if (k <= 4)    return 3;
    else if (k <= 11)   return 4;
    else if (k <= 26)   return 5;
    else if (k <= 57)   return 6;
    else if (k <= 120)  return 7;
    else if (k <= 247)  return 8;
    else if (k <= 502)  return 9;
    else if (k <= 1013) return 10;
    else                return 11;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bit idx lives at the idx-th non-power-of-two position (3,5,6,7,9,...).
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < idx + 16; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Inverse of data_pos for a non-power-of-two position.
  function automatic int pos_to_index(input int pos);
    return pos - $clog2(pos + 1) - 1;
  endfunction

endpackage

// File: rtl/hd_syndrome_gen.sv
// Stage 2 of the Hamming decoder: syndrome of the registered codeword,
// delivered from a register.
module hd_syndrome_gen import hamming_pkg::*; #(
  parameter int K = 8,
  parameter int M = calc_m(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K+M-1:0] cw,
  output logic [M-1:0]   syn
);

  logic [M-1:0] contrib [K];
  logic [M-1:0] syn_d;
  logic [M-1:0] syn_q;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_col
      localparam int POS = data_pos(gi);
      // A set data bit contributes its own position to the syndrome.
      assign contrib[gi] = cw[gi] ? POS[M-1:0] : '0;
    end
  endgenerate

  always_comb begin
    syn_d = cw[K+M-1:K];
    for (int i = 0; i < K; i++) syn_d = syn_d ^ contrib[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) syn_q <= '0;
    else      syn_q <= syn_d;
  end

  assign syn = syn_q;

endmodule

// File: rtl/hd_top.sv
// Three-stage Hamming SEC decoder: input reg -> syndrome reg -> corrected output reg.
// Define HD_ERR_CNT_EN to build the saturating 16-bit error event counter.
module hd_top import hamming_pkg::*; #(
  parameter  int K = 8,
  localparam int M = calc_m(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cvld,
  input  logic [K+M-1:0] cin,
  output logic           dvld,
  output logic [K-1:0]   dout,
  output logic           err_corr,
  output logic           err_unc,
  input  logic           cnt_clr,
  output logic [15:0]    err_cnt
);

  localparam int N = K + M;

  logic           vld1_d, vld1_q;
  logic [N-1:0]   cw1_d, cw1_q;
  logic           vld2_d, vld2_q;
  logic [K-1:0]   data2_d, data2_q;
  logic [M-1:0]   syn2;
  logic           dvld_d, dvld_q;
  logic [K-1:0]   dout_d, dout_q;
  logic           corr_d, corr_q;
  logic           unc_d, unc_q;
  logic [K-1:0]   fix_mask;
  hd_status_e     status;

  always_comb begin
    vld1_d  = cvld;
    cw1_d   = cin;
    vld2_d  = vld1_q;
    data2_d = cw1_q[K-1:0];
  end

  hd_syndrome_gen #(.K(K), .M(M)) u_syn (
    .clk (clk),
    .rst (rst),
    .cw  (cw1_q),
    .syn (syn2)
  );

  // Only a syndrome equal to a data position flips a data bit.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_fix
      localparam int POS = data_pos(gi);
      assign fix_mask[gi] = (int'(syn2) == POS);
    end
  endgenerate

  always_comb begin
    status = HD_OK;
    if (int'(syn2) > N)   status = HD_UNC;
    else if (syn2 != '0)  status = HD_CORR;
  end

  always_comb begin
    dvld_d = vld2_q;
    dout_d = dout_q;
    corr_d = 1'b0;
    unc_d  = 1'b0;
    if (vld2_q) begin
      dout_d = data2_q ^ fix_mask;
      corr_d = (status == HD_CORR);
      unc_d  = (status == HD_UNC);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1_q  <= 1'b0;
      cw1_q   <= '0;
      vld2_q  <= 1'b0;
      data2_q <= '0;
      dvld_q  <= 1'b0;
      dout_q  <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      vld1_q  <= vld1_d;
      cw1_q   <= cw1_d;
      vld2_q  <= vld2_d;
      data2_q <= data2_d;
      dvld_q  <= dvld_d;
      dout_q  <= dout_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  assign dvld     = dvld_q;
  assign dout     = dout_q;
  assign err_corr = corr_q;
  assign err_unc  = unc_q;

`ifdef HD_ERR_CNT_EN
  logic [15:0] err_cnt_d, err_cnt_q;

  // Clear has priority over a same-cycle error event.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr)
      err_cnt_d = '0;
    else if (dvld_q && (corr_q || unc_q) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_hd_top.sv
// Directed bench for hd_top at K=8 (M=4); codewords are hand-encoded constants.
// Counter saturation checks are built when HD_ERR_CNT_EN is defined.
module tb_hd_top;

  localparam int K = 8;
  localparam int N = 12;
`ifdef HD_ERR_CNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cvld = 1'b0;
  logic [N-1:0]  cin = '0;
  logic          cnt_clr = 1'b0;
  logic          dvld;
  logic [K-1:0]  dout;
  logic          err_corr;
  logic          err_unc;
  logic [15:0]   err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd_top #(.K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .cvld     (cvld),
    .cin      (cin),
    .dvld     (dvld),
    .dout     (dout),
    .err_corr (err_corr),
    .err_unc  (err_unc),
    .cnt_clr  (cnt_clr),
    .err_cnt  (err_cnt)
  );

  // Presents one codeword for one cycle and captures the first dvld within 8 cycles.
  task automatic run_one(input logic [N-1:0] cw, output int lat, output logic [K-1:0] d,
                         output logic c, output logic u);
    lat = -1; d = '0; c = 1'b0; u = 1'b0;
    cin = cw; cvld = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin cvld = 1'b0; cin = '0; end
      if (dvld && lat < 0) begin lat = n; d = dout; c = err_corr; u = err_unc; end
    end
  endtask

  // Streams n back-to-back codewords with a data error, then drains.
  task automatic stream_err(input int n);
    cin = 12'h008; cvld = 1'b1;
    repeat (n) @(negedge clk);
    cvld = 1'b0; cin = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; cvld = 1'b1; cin = 12'h3A5;
    repeat (3) @(negedge clk);
    $display("reset   dvld=%b dout=%h corr=%b unc=%b cnt=%h", dvld, dout, err_corr, err_unc, err_cnt);
    n_checks++; if (dvld !== 1'b0) begin n_fail++; $display("FAIL reset_dvld: got %b want 0", dvld); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_checks++; if (err_corr !== 1'b0 || err_unc !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got corr=%b unc=%b want 0 0", err_corr, err_unc); end
    n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", err_cnt); end
    cvld = 1'b0; cin = '0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean;
    logic [N-1:0] cw_t [2] = '{12'h3A5, 12'h3FF};
    logic [K-1:0] d_t  [2] = '{8'hA5, 8'hFF};
    int lat; logic [K-1:0] d; logic c, u;
    for (int i = 0; i < 2; i++) begin
      run_one(cw_t[i], lat, d, c, u);
      $display("clean   cin=%h dout=%h corr=%b unc=%b lat=%0d", cw_t[i], d, c, u, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL clean_lat: got %0d want 3", lat); end
      n_checks++; if (d !== d_t[i]) begin n_fail++; $display("FAIL clean_dout: got %h want %h", d, d_t[i]); end
      n_checks++; if (c !== 1'b0 || u !== 1'b0) begin
        n_fail++; $display("FAIL clean_flags: got corr=%b unc=%b want 0 0", c, u); end
    end
  endtask

  task automatic test_data_err;
    logic [N-1:0] cw_t [3] = '{12'h008, 12'h325, 12'h3A4};
    logic [K-1:0] d_t  [3] = '{8'h00, 8'hA5, 8'hA5};
    int lat; logic [K-1:0] d; logic c, u;
    for (int i = 0; i < 3; i++) begin
      run_one(cw_t[i], lat, d, c, u);
      $display("dataerr cin=%h dout=%h corr=%b unc=%b lat=%0d", cw_t[i], d, c, u, lat);
      n_checks++; if (d !== d_t[i]) begin n_fail++; $display("FAIL dataerr_dout: got %h want %h", d, d_t[i]); end
      n_checks++; if (c !== 1'b1 || u !== 1'b0) begin
        n_fail++; $display("FAIL dataerr_flags: got corr=%b unc=%b want 1 0", c, u); end
    end
  endtask

  task automatic test_parity_err;
    logic [N-1:0] cw_t [3] = '{12'h400, 12'h2A5, 12'hBA5};
    logic [K-1:0] d_t  [3] = '{8'h00, 8'hA5, 8'hA5};
    int lat; logic [K-1:0] d; logic c, u;
    for (int i = 0; i < 3; i++) begin
      run_one(cw_t[i], lat, d, c, u);
      $display("parerr  cin=%h dout=%h corr=%b unc=%b lat=%0d", cw_t[i], d, c, u, lat);
      n_checks++; if (d !== d_t[i]) begin n_fail++; $display("FAIL parerr_dout: got %h want %h", d, d_t[i]); end
      n_checks++; if (c !== 1'b1 || u !== 1'b0) begin
        n_fail++; $display("FAIL parerr_flags: got corr=%b unc=%b want 1 0", c, u); end
    end
  endtask

  task automatic test_unc;
    logic [N-1:0] cw_t [3] = '{12'h410, 12'h081, 12'h280};
    logic [K-1:0] d_t  [3] = '{8'h10, 8'h81, 8'h80};
    int lat; logic [K-1:0] d; logic c, u;
    for (int i = 0; i < 3; i++) begin
      run_one(cw_t[i], lat, d, c, u);
      $display("unc     cin=%h dout=%h corr=%b unc=%b lat=%0d", cw_t[i], d, c, u, lat);
      n_checks++; if (d !== d_t[i]) begin n_fail++; $display("FAIL unc_dout: got %h want %h", d, d_t[i]); end
      n_checks++; if (c !== 1'b0 || u !== 1'b1) begin
        n_fail++; $display("FAIL unc_flags: got corr=%b unc=%b want 0 1", c, u); end
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] cw_t [5] = '{12'h3A5, 12'h008, 12'h3FF, 12'h400, 12'h000};
    logic [K-1:0] d_t  [5] = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic [4:0]   c_exp = 5'b01010;
    logic [15:0]  exp_cnt;
    int lat; logic [K-1:0] d; logic c, u;
    int k;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int cy = 0; cy < 10; cy++) begin
      k = cy - 3;
      if (k >= 0 && k < 5) begin
        $display("b2b[%0d]  dvld=%b dout=%h corr=%b unc=%b", k, dvld, dout, err_corr, err_unc);
        n_checks++;
        if (dvld !== 1'b1 || dout !== d_t[k] || err_corr !== c_exp[k] || err_unc !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_out[%0d]: got dvld=%b dout=%h corr=%b unc=%b want 1 %h %b 0",
                   k, dvld, dout, err_corr, err_unc, d_t[k], c_exp[k]);
        end
      end else begin
        n_checks++;
        if (dvld !== 1'b0 || err_corr !== 1'b0 || err_unc !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle[%0d]: got dvld=%b corr=%b unc=%b want 0 0 0", cy, dvld, err_corr, err_unc);
        end
      end
      cvld = (cy < 5);
      cin  = (cy < 5) ? cw_t[cy] : '0;
      @(negedge clk);
    end
    @(negedge clk);
    exp_cnt = CNT_EN ? 16'd2 : 16'd0;
    $display("b2b     err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %h want %h", err_cnt, exp_cnt); end

    // Two errored codewords in flight, then reset.
    cvld = 1'b1; cin = 12'h008; @(negedge clk);
    cin = 12'h410;              @(negedge clk);
    cvld = 1'b0; cin = '0; rst = 1'b0;
    @(negedge clk);
    $display("b2b rst dvld=%b dout=%h cnt=%h", dvld, dout, err_cnt);
    n_checks++; if (dvld !== 1'b0 || dout !== 8'h00 || err_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid: got dvld=%b dout=%h cnt=%h want 0 00 0000", dvld, dout, err_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int cy = 0; cy < 6; cy++) begin
      @(negedge clk);
      n_checks++; if (dvld !== 1'b0 || err_corr !== 1'b0 || err_unc !== 1'b0) begin
        n_fail++; $display("FAIL rst_flush[%0d]: got dvld=%b corr=%b unc=%b want 0 0 0", cy, dvld, err_corr, err_unc); end
    end
    n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0000", err_cnt); end

    run_one(12'h3A5, lat, d, c, u);
    $display("postrst cin=3a5 dout=%h corr=%b unc=%b lat=%0d", d, c, u, lat);
    n_checks++; if (lat !== 3 || d !== 8'hA5) begin
      n_fail++; $display("FAIL postrst: got lat=%0d dout=%h want 3 a5", lat, d); end
  endtask

  task automatic test_counter;
`ifdef HD_ERR_CNT_EN
    int lat; logic [K-1:0] d; logic c, u;
    stream_err(65532);
    $display("cnt     after 65532 events err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'hFFFC) begin n_fail++; $display("FAIL cnt_preload: got %h want fffc", err_cnt); end
    stream_err(3);
    $display("cnt     after 3 more err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_reach_max: got %h want ffff", err_cnt); end
    stream_err(2);
    $display("cnt     after 2 more err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", err_cnt); end
    // Clear lands in the same cycle as an error event.
    cin = 12'h008; cvld = 1'b1;
    @(negedge clk); cvld = 1'b0; cin = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (dvld !== 1'b1 || err_corr !== 1'b1) begin
      n_fail++; $display("FAIL cnt_clr_event: got dvld=%b corr=%b want 1 1", dvld, err_corr); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    @(negedge clk);
    $display("cnt     clear with event err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL cnt_clear_wins: got %h want 0000", err_cnt); end
    run_one(12'h410, lat, d, c, u);
    $display("cnt     one unc event err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'h1) begin n_fail++; $display("FAIL cnt_after_clr: got %h want 0001", err_cnt); end
`else
    cnt_clr = 1'b1;
    stream_err(3);
    cnt_clr = 1'b0;
    stream_err(2);
    $display("cnt     disabled err_cnt=%h", err_cnt);
    n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL cnt_disabled: got %h want 0000", err_cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_clean;
    test_data_err;
    test_parity_err;
    test_unc;
    test_back_to_back;
    test_counter;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hd_top.md
HD_TOP -- requirements
Module: hd_top

Interface
REQ-001 SHALL have parameter K, default 8: number of data bits, legal range 1..2036.
REQ-002 SHALL derive localparam M from K: K=1 -> 2; K<=4 -> 3; <=11 -> 4; <=26 -> 5; <=57 -> 6; <=120 -> 7; <=247 -> 8; <=502 -> 9; <=1013 -> 10; else 11.
REQ-003 SHALL have port clk, input, 1: clock; all state rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cvld, input, 1: codeword valid.
REQ-006 SHALL have port cin, input, K+M: codeword {parity[M-1:0], data[K-1:0]}.
REQ-007 SHALL have port dvld, output, 1: decoded data valid.
REQ-008 SHALL have port dout, output, K: corrected data.
REQ-009 SHALL have port err_corr, output, 1: single-bit error corrected (data or parity bit), qualified by dvld.
REQ-010 SHALL have port err_unc, output, 1: syndrome points outside the codeword, so the error is uncorrectable; qualified by dvld.
REQ-011 SHALL have port cnt_clr, input, 1: synchronous clear of err_cnt.
REQ-012 SHALL have port err_cnt, output, 16: error event counter.

Function
REQ-013 SHALL place the codeword in Hamming positions 1..K+M: parity[j] at position 2^j; data[i] at the i-th non-power-of-two position, ascending (K=8: d0..d7 at 3,5,6,7,9,10,11,12).
REQ-014 SHALL define the syndrome bit s[j] as parity[j] XOR the XOR of all data bits whose position has bit j set.
REQ-015 SHALL pipeline decoding in three stages: input register, then syndrome register, then output register; dvld asserts exactly 3 clocks after cvld is sampled high.
REQ-016 SHALL accept one codeword per cycle, with no backpressure; dvld SHALL follow cvld delayed by 3 cycles, including gaps.
REQ-017 For a syndrome of 0, SHALL output the data unchanged with err_corr=0 and err_unc=0.
REQ-018 For a syndrome equal to a data position, SHALL invert that data bit in dout and set err_corr=1.
REQ-019 For a syndrome equal to 2^j with j<M, SHALL output the data unchanged and set err_corr=1.
REQ-020 For a syndrome greater than K+M, SHALL output the data unchanged, set err_unc=1 and set err_corr=0.
REQ-021 When dvld=0, SHALL hold err_corr and err_unc at 0; dout value is don't-care.

Reset
REQ-022 While rst=0, SHALL clear all pipeline registers; dvld, dout, err_corr, err_unc and err_cnt SHALL read 0.
REQ-023 Reset mid-stream SHALL discard all in-flight codewords; none of them SHALL produce dvld after rst is released.
REQ-024 The first cvld sampled after reset release SHALL produce dvld 3 cycles later.

Configuration
REQ-025 With macro HD_ERR_CNT_EN defined, err_cnt SHALL increment by 1 in each cycle where dvld=1 and (err_corr or err_unc)=1.
REQ-026 With HD_ERR_CNT_EN defined, err_cnt SHALL saturate at 16'hFFFF.
REQ-027 With HD_ERR_CNT_EN defined, cnt_clr=1 SHALL load 0 on the next edge; if clear and increment occur in the same cycle, clear wins.
REQ-028 Without HD_ERR_CNT_EN, err_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL exist; ports are unchanged.

Structure
REQ-029 SHALL source the K-to-M mapping function and the position/index mapping helpers from shared package hamming_pkg, which is also used by the encoder.
REQ-030 SHALL compute the syndrome in sub-module hd_syndrome_gen, with parameters K and M; its input is the registered codeword and its output is the registered syndrome (stage 2).
REQ-031 SHALL generate the correction mask combinationally from the syndrome in stage 3 of hd_top.

Verification (K=8, M=4)
REQ-032 Clean stream: SHALL encode 8'hA5 with he_top, send it to hd_top -> dout=8'hA5, err_corr=0, err_unc=0, dvld 3 cycles after cvld.
REQ-033 Data error: SHALL use codeword for 8'h00 with cin[3] flipped (syndrome 4'b0111) -> dout=8'h00, err_corr=1.
REQ-034 Parity error: SHALL use codeword for 8'h00 with cin[10] flipped (parity[2], syndrome 4'b0100) -> dout=8'h00, err_corr=1.
REQ-035 Uncorrectable error: SHALL use codeword for 8'h00 with cin[4] and cin[10] flipped (syndrome 13) -> dout=8'h10, err_unc=1, err_corr=0.
REQ-036 Back-to-back and reset: SHALL drive 5 consecutive codewords with 2 errored, then assert rst with 2 codewords in flight -> err_cnt=2, no dvld after release, err_cnt=0.
REQ-037 Counter saturation and clear (HD_ERR_CNT_EN): SHALL preload err_cnt near 16'hFFFF via 3 further error events -> err_cnt holds 16'hFFFF; cnt_clr coinciding with an error event -> err_cnt=0.
